// File: rtl/cu_prefetch_command_buffer.sv
// Prefetch command buffer: sits after the prefetch stream engine control,
// queues its commands in a FIFO, reports FIFO status back to the engine,
// and issues commands to the CU command arbiter one per grant while capping
// the number of commands still waiting for a matching response.

package cu_prefetch_pkg;
  localparam logic [7:0] PREFETCH_READ_CONTROL_ID = 8'h12;

  typedef struct packed {
    logic [7:0] cu_id;
    logic [7:0] tag;
  } CommandMeta;

  typedef struct packed {
    logic        valid;
    logic [63:0] address;
    logic [31:0] real_size;
    CommandMeta  cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic       valid;
    CommandMeta cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;
endpackage

// Handshake: a command is issued at a posedge where command_request and
// command_grant are both 1; prefetch_command_out then carries it with
// valid=1 for that single cycle. A grant without a request does nothing.
module cu_prefetch_command_buffer
  import cu_prefetch_pkg::*;
#(
  parameter int         BUFFER_DEPTH           = 16,
  parameter int         ALFULL_MARGIN          = 4,
  parameter int         MAX_OUTSTANDING        = 32,
  parameter logic [7:0] CU_PREFETCH_CONTROL_ID = PREFETCH_READ_CONTROL_ID
) (
  input  logic                                     clock,
  input  logic                                     rstn,
  input  logic                                     enabled_in,
  input  CommandBufferLine                         prefetch_command_in,
  input  ResponseBufferLine                        prefetch_response_in,
  input  logic                                     command_grant,
  output logic                                     command_request,
  output CommandBufferLine                         prefetch_command_out,
  output BufferStatus                              prefetch_command_buffer_status,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_count,
  output logic                                     overflow_error,
  output logic                                     underflow_error
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(BUFFER_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ALFULL = OCC_W'(BUFFER_DEPTH - ALFULL_MARGIN);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);

  logic              enabled;
  CommandBufferLine  cmd_q;
  ResponseBufferLine rsp_q;
  CommandBufferLine  mem [BUFFER_DEPTH];
  CommandBufferLine  head_line;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic              push;
  logic              push_accept;
  logic              pop;
  logic              retire;

  // Request depends only on registered state, never on same-cycle inputs.
  assign command_request = ~prefetch_command_buffer_status.empty & enabled &
                           (outstanding_count < CNT_MAX);

  // Push/pop/retire decode and next occupancy; a pop frees the slot a full push needs.
  always_comb begin
    push        = cmd_q.valid;
    pop         = command_grant & command_request;
    push_accept = push & (~prefetch_command_buffer_status.full | pop);
    retire      = rsp_q.valid & (rsp_q.cmd.cu_id == CU_PREFETCH_CONTROL_ID);
    head_line       = mem[rd_ptr];
    head_line.valid = 1'b1;
    occ_next = occ;
    case ({push_accept, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  // Input stage: latch engine command and response; disabled loads zero.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled <= 1'b0;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      enabled <= enabled_in;
      cmd_q   <= enabled ? prefetch_command_in : '0;
      rsp_q   <= enabled ? prefetch_response_in : '0;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge clock) begin
    if (push_accept) mem[wr_ptr] <= cmd_q;
  end

  // FIFO pointers, occupancy, registered status and sticky overflow.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      prefetch_command_buffer_status <= '{empty: 1'b1, full: 1'b0, alfull: 1'b0};
      overflow_error <= 1'b0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)         rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ_next;
      prefetch_command_buffer_status.empty  <= (occ_next == '0);
      prefetch_command_buffer_status.full   <= (occ_next == OCC_FULL);
      prefetch_command_buffer_status.alfull <= (occ_next >= OCC_ALFULL);
      if (push && !push_accept) overflow_error <= 1'b1;
    end
  end

  // Issue register: one-cycle pulse of the popped head entry.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) prefetch_command_out <= '0;
    else       prefetch_command_out <= pop ? head_line : '0;
  end

  // Outstanding counter: +1 per issue, -1 per matching response, floor at 0.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      outstanding_count <= '0;
      underflow_error   <= 1'b0;
    end else begin
      case ({pop, retire})
        2'b10: outstanding_count <= outstanding_count + CNT_W'(1);
        2'b01: begin
          if (outstanding_count == '0) underflow_error <= 1'b1;
          else outstanding_count <= outstanding_count - CNT_W'(1);
        end
        default: outstanding_count <= outstanding_count;
      endcase
    end
  end

endmodule
